display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-cathode 7-segment display. It steps one shared BCD-to-7-segment decoder through N digits. For each digit slot it presents that digit's BCD code and decimal point, then drives the matching digit-select line after a ghost-blanking interval. New display values are double-buffered and committed only at frame boundaries, so a displayed frame never tears. Suppression of leading zeros is optional.

Parameters:
N_DIGITS, 4, number of digits scanned; digit 0 is rightmost/least significant.
CLK_HZ, 50000000, input clock frequency in Hz.
REFRESH_HZ, 1000, digit slot rate; DIGIT_PERIOD = CLK_HZ/REFRESH_HZ clock cycles per slot.
BLANK_CYCLES, 500, blanking cycles at the start of each slot; must satisfy 1 <= BLANK_CYCLES < DIGIT_PERIOD.
SEL_ACTIVE_LOW, 0, if 1, digit_sel is inverted at the output.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
bcd_in  in  4*N_DIGITS  BCD digits; digit i is at [4i+3:4i]
dp_in  in  N_DIGITS  decimal point per digit
load  in  1  one-cycle strobe that captures bcd_in/dp_in
lzb_en  in  1  enables leading-zero blanking
blank_all  in  1  forces all digits off; scanning continues
bcd_out  out  4  BCD code to the decoder
dp_out  out  1  decimal point to the decoder
digit_sel  out  N_DIGITS  one-hot digit enable
frame_done  out  1  one-cycle pulse on the last cycle of each frame
load_ack  out  1  one-cycle pulse when held data is committed to the display

Behaviour:
- Reset (rst sampled high on a rising edge):
  - Scan goes to digit 0, state BLANK, slot counter 0.
  - Holding, display and pending registers are cleared.
  - bcd_out=0, dp_out=0, frame_done=0, load_ack=0.
  - digit_sel is inactive: all 0, or all 1 if SEL_ACTIVE_LOW.
  - Reset asserted mid-frame aborts the frame immediately.
- Scan FSM, states BLANK and SHOW:
  - BLANK lasts BLANK_CYCLES cycles, then goes to SHOW.
  - SHOW lasts DIGIT_PERIOD-BLANK_CYCLES cycles, then goes to BLANK of digit (idx+1) mod N_DIGITS.
  - Frame length is N_DIGITS*DIGIT_PERIOD cycles.
- Data outputs:
  - bcd_out and dp_out are registered.
  - They take digit idx's display value on the first cycle of that digit's BLANK and stay stable through its SHOW.
  - BCD codes >9 pass through unchanged.
- digit_sel:
  - Registered and one-hot, asserted only during SHOW, from the first through the last SHOW cycle.
  - It is inactive in BLANK, inactive while blank_all is high (effective the cycle after it rises), and inactive for a suppressed digit.
- Leading-zero blanking (lzb_en=1):
  - Digit i>0 is suppressed when it and every higher digit have BCD 0 and dp 0.
  - Digit 0 is never suppressed.
  - Evaluation uses the display register, not the holding register.
- Load:
  - load captures bcd_in/dp_in into the holding register and sets pending.
  - A later load in the same frame overwrites the holding register; the last load wins.
- Frame boundary (last SHOW cycle of digit N-1):
  - frame_done=1.
  - If load=1 on this cycle, bcd_in/dp_in go directly to the display register and load_ack=1.
  - Else if pending=1, holding goes to display and load_ack=1.
  - pending is cleared in both cases. The new values appear from digit 0 of the next frame.
- Pulses: frame_done and load_ack are high for exactly one cycle each.

Test Plan:
Bench parameters: CLK_HZ=1000, REFRESH_HZ=100 (DIGIT_PERIOD=10), BLANK_CYCLES=2, N_DIGITS=4, SEL_ACTIVE_LOW=0. Cycle 0 is the first cycle after rst falls.
1. Reset and scan:
   - During rst: digit_sel=0000, bcd_out=0, dp_out=0.
   - digit_sel=0001 on cycles 2-9 and 0010 on cycles 12-19, 0 on cycles 0-1 and 10-11.
   - frame_done on cycle 39 and cycle 79.
2. Double-buffered load:
   - Drive load with bcd_in=16'h1234, dp_in=4'b0100 at cycle 15.
   - Outputs still 0 through cycle 39; load_ack at cycle 39.
   - Next frame: bcd_out 4,3,2,1 for digits 0..3; dp_out=1 only during digit 2's slot.
3. Leading-zero blanking, lzb_en=1:
   - 16'h0050: digits 3 and 2 never selected; digit 1 shows 5, digit 0 shows 0.
   - 16'h0000: only digit 0 selected.
   - 16'h0005 with dp_in=4'b0100: digit 2 shown as 0 with dp; digit 3 suppressed.
4. Load timing:
   - load at cycle 39 (boundary) with 16'h9999: committed that cycle, load_ack=1, shown in the next frame.
   - Loads at cycles 5 and 20: only the cycle-20 value appears, with a single load_ack.
5. blank_all:
   - Assert at cycle 4: digit_sel=0000 from cycle 5 onward.
   - bcd_out keeps stepping through the digits; frame_done still pulses every 40 cycles.
6. Reset mid-frame:
   - With a loaded frame running, assert rst at cycle 25 for one cycle.
   - Outputs and pending are cleared; scan restarts at digit 0 BLANK; no load_ack at the old boundary.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a common-cathode multi-digit 7-segment
// display. One shared decoder is stepped through the digits; each slot starts
// with a ghost-blanking interval before the digit is enabled. New values are
// double-buffered and committed only at frame boundaries.
module display_scan_ctrl #(
    parameter int N_DIGITS       = 4,
    parameter int CLK_HZ         = 50000000,
    parameter int REFRESH_HZ     = 1000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  load,
    input  logic                  lzb_en,
    input  logic                  blank_all,
    output logic [3:0]            bcd_out,
    output logic                  dp_out,
    output logic [N_DIGITS-1:0]   digit_sel,
    output logic                  frame_done,
    output logic                  load_ack
);

    localparam int DIGIT_PERIOD = CLK_HZ / REFRESH_HZ;
    localparam int CNT_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DIGIT_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    scan_state_t           state, next_state;
    logic [IDX_W-1:0]      idx, next_idx;
    logic [CNT_W-1:0]      cnt, next_cnt;

    logic [4*N_DIGITS-1:0] hold_bcd, hold_bcd_d;
    logic [N_DIGITS-1:0]   hold_dp, hold_dp_d;
    logic                  pending, pending_d;
    logic [4*N_DIGITS-1:0] disp_bcd, disp_bcd_d;
    logic [N_DIGITS-1:0]   disp_dp, disp_dp_d;
    logic                  at_boundary;
    logic                  commit;

    logic [N_DIGITS-1:0]   suppress;
    logic                  zero_run;
    logic [3:0]            bcd_d;
    logic                  dp_d;
    logic [N_DIGITS-1:0]   sel_d, sel_q;

    // Scan state register: current phase, digit index and slot cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BLANK;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
            cnt   <= next_cnt;
        end
    end

    // Next-state logic: BLANK for the first part of the slot, SHOW for the rest, then next digit.
    always_comb begin
        next_state = state;
        next_idx   = idx;
        next_cnt   = cnt + CNT_W'(1);
        if (state == BLANK) begin
            if (cnt == BLANK_LAST) begin
                next_state = SHOW;
            end
        end else begin
            if (cnt == SLOT_LAST) begin
                next_state = BLANK;
                next_cnt   = '0;
                next_idx   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end
        end
    end

    assign at_boundary = (state == SHOW) && (idx == IDX_LAST) && (cnt == SLOT_LAST);

    // Double buffering: loads land in the holding register, commits happen only at the frame boundary.
    always_comb begin
        hold_bcd_d = hold_bcd;
        hold_dp_d  = hold_dp;
        pending_d  = pending;
        disp_bcd_d = disp_bcd;
        disp_dp_d  = disp_dp;
        commit     = 1'b0;
        if (at_boundary) begin
            pending_d = 1'b0;
            if (load) begin
                disp_bcd_d = bcd_in;
                disp_dp_d  = dp_in;
                commit     = 1'b1;
            end else if (pending) begin
                disp_bcd_d = hold_bcd;
                disp_dp_d  = hold_dp;
                commit     = 1'b1;
            end
        end else if (load) begin
            hold_bcd_d = bcd_in;
            hold_dp_d  = dp_in;
            pending_d  = 1'b1;
        end
    end

    // Holding, pending and display registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_bcd <= '0;
            hold_dp  <= '0;
            pending  <= 1'b0;
            disp_bcd <= '0;
            disp_dp  <= '0;
        end else begin
            hold_bcd <= hold_bcd_d;
            hold_dp  <= hold_dp_d;
            pending  <= pending_d;
            disp_bcd <= disp_bcd_d;
            disp_dp  <= disp_dp_d;
        end
    end

    // Leading-zero suppression: walk down from the top digit while digits are blank zeros.
    always_comb begin
        suppress = '0;
        zero_run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run && (disp_bcd_d[4*i +: 4] == 4'd0) && !disp_dp_d[i];
            suppress[i] = lzb_en && zero_run;
        end
    end

    // Output decode: values for the digit the scan is about to be on, so the registers line up with it.
    always_comb begin
        bcd_d = 4'd0;
        dp_d  = 1'b0;
        sel_d = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (next_idx == IDX_W'(i)) begin
                bcd_d = disp_bcd_d[4*i +: 4];
                dp_d  = disp_dp_d[i];
                if ((next_state == SHOW) && !blank_all && !suppress[i]) begin
                    sel_d[i] = 1'b1;
                end
            end
        end
    end

    // Registered decoder and digit-select outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_out <= 4'd0;
            dp_out  <= 1'b0;
            sel_q   <= '0;
        end else begin
            bcd_out <= bcd_d;
            dp_out  <= dp_d;
            sel_q   <= sel_d;
        end
    end

    assign digit_sel  = SEL_ACTIVE_LOW ? ~sel_q : sel_q;
    assign frame_done = at_boundary && !rst;
    assign load_ack   = commit && !rst;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with a 10-cycle digit slot,
// 2 blanking cycles and 4 digits. Cycle 0 is the first cycle after rst falls.
module tb_display_scan_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        lzb_en;
    logic        blank_all;
    logic [3:0]  bcd_out;
    logic        dp_out;
    logic [3:0]  digit_sel;
    logic        frame_done;
    logic        load_ack;

    int cyc;
    int checks;
    int errors;

    typedef struct {
        bit          start;
        int          cyc;
        bit          ld;
        logic [15:0] bcd;
        logic [3:0]  dp;
        bit          lzb;
        bit          blank;
        logic [3:0]  e_sel;
        logic [3:0]  e_bcd;
        logic        e_dp;
        logic        e_fd;
        logic        e_ack;
    } vec_t;

    vec_t vecs[$];

    display_scan_ctrl #(
        .N_DIGITS      (4),
        .CLK_HZ        (1000),
        .REFRESH_HZ    (100),
        .BLANK_CYCLES  (2),
        .SEL_ACTIVE_LOW(1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bcd_in    (bcd_in),
        .dp_in     (dp_in),
        .load      (load),
        .lzb_en    (lzb_en),
        .blank_all (blank_all),
        .bcd_out   (bcd_out),
        .dp_out    (dp_out),
        .digit_sel (digit_sel),
        .frame_done(frame_done),
        .load_ack  (load_ack)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle number relative to the last reset.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input int c, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, c, act, exp);
        end
    endtask

    task automatic checkAll(input int c, input logic [3:0] es, input logic [3:0] eb,
                            input logic ed, input logic ef, input logic ea);
        checkOutput("digit_sel", c, digit_sel, es);
        checkOutput("bcd_out", c, bcd_out, eb);
        checkOutput("dp_out", c, {3'b0, dp_out}, {3'b0, ed});
        checkOutput("frame_done", c, {3'b0, frame_done}, {3'b0, ef});
        checkOutput("load_ack", c, {3'b0, load_ack}, {3'b0, ea});
    endtask

    // Step to 1 time unit after the edge that starts cycle c; load is a one-cycle strobe.
    task automatic gotoCycle(input int c);
        int guard;
        guard = 0;
        while (cyc != c && guard < 5000) begin
            @(posedge clk);
            #1;
            load = 1'b0;
            guard++;
        end
        if (cyc != c) begin
            checks++;
            errors++;
            $display("[TB] FAIL gotoCycle: reached cycle %0d, wanted %0d", cyc, c);
        end
    endtask

    task automatic doReset();
        rst       = 1'b1;
        load      = 1'b0;
        lzb_en    = 1'b0;
        blank_all = 1'b0;
        bcd_in    = 16'h0;
        dp_in     = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        checkAll(-1, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        load      = v.ld;
        bcd_in    = v.bcd;
        dp_in     = v.dp;
        lzb_en    = v.lzb;
        blank_all = v.blank;
    endtask

    task automatic add(input bit st, input int c, input bit ld, input logic [15:0] b, input logic [3:0] d,
                       input bit lz, input bit bl, input logic [3:0] es, input logic [3:0] eb,
                       input logic ed, input logic ef, input logic ea);
        vec_t v;
        v.start = st; v.cyc = c; v.ld = ld; v.bcd = b; v.dp = d; v.lzb = lz; v.blank = bl;
        v.e_sel = es; v.e_bcd = eb; v.e_dp = ed; v.e_fd = ef; v.e_ack = ea;
        vecs.push_back(v);
    endtask

    int fd_count;
    int ack_count;

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        load      = 1'b0;
        lzb_en    = 1'b0;
        blank_all = 1'b0;
        bcd_in    = 16'h0;
        dp_in     = 4'h0;

        // Scan timing and double-buffered load of 1234, dp on digit 2.
        add(1,  0, 0, 16'h0000, 4'b0000, 0, 0, 4'b0000, 4'h0, 0, 0, 0);
        add(0,  1, 0, 16'h0000, 4'b0000, 0, 0, 4'b0000, 4'h0, 0, 0, 0);
        add(0,  2, 0, 16'h0000, 4'b0000, 0, 0, 4'b0001, 4'h0, 0, 0, 0);
        add(0,  9, 0, 16'h0000, 4'b0000, 0, 0, 4'b0001, 4'h0, 0, 0, 0);
        add(0, 10, 0, 16'h0000, 4'b0000, 0, 0, 4'b0000, 4'h0, 0, 0, 0);
        add(0, 11, 0, 16'h0000, 4'b0000, 0, 0, 4'b0000, 4'h0, 0, 0, 0);
        add(0, 12, 0, 16'h0000, 4'b0000, 0, 0, 4'b0010, 4'h0, 0, 0, 0);
        add(0, 15, 1, 16'h1234, 4'b0100, 0, 0, 4'b0010, 4'h0, 0, 0, 0);
        add(0, 19, 0, 16'h1234, 4'b0100, 0, 0, 4'b0010, 4'h0, 0, 0, 0);
        add(0, 20, 0, 16'h1234, 4'b0100, 0, 0, 4'b0000, 4'h0, 0, 0, 0);
        add(0, 22, 0, 16'h1234, 4'b0100, 0, 0, 4'b0100, 4'h0, 0, 0, 0);
        add(0, 32, 0, 16'h1234, 4'b0100, 0, 0, 4'b1000, 4'h0, 0, 0, 0);
        add(0, 38, 0, 16'h1234, 4'b0100, 0, 0, 4'b1000, 4'h0, 0, 0, 0);
        add(0, 39, 0, 16'h1234, 4'b0100, 0, 0, 4'b1000, 4'h0, 0, 1, 1);
        add(0, 40, 0, 16'h1234, 4'b0100, 0, 0, 4'b0000, 4'h4, 0, 0, 0);
        add(0, 42, 0, 16'h1234, 4'b0100, 0, 0, 4'b0001, 4'h4, 0, 0, 0);
        add(0, 52, 0, 16'h1234, 4'b0100, 0, 0, 4'b0010, 4'h3, 0, 0, 0);
        add(0, 60, 0, 16'h1234, 4'b0100, 0, 0, 4'b0000, 4'h2, 1, 0, 0);
        add(0, 62, 0, 16'h1234, 4'b0100, 0, 0, 4'b0100, 4'h2, 1, 0, 0);
        add(0, 72, 0, 16'h1234, 4'b0100, 0, 0, 4'b1000, 4'h1, 0, 0, 0);
        add(0, 79, 0, 16'h1234, 4'b0100, 0, 0, 4'b1000, 4'h1, 0, 1, 0);
        add(0, 80, 0, 16'h1234, 4'b0100, 0, 0, 4'b0000, 4'h4, 0, 0, 0);

        // Leading-zero blanking.
        add(1,   0, 1, 16'h0050, 4'b0000, 1, 0, 4'b0000, 4'h0, 0, 0, 0);
        add(0,  12, 0, 16'h0050, 4'b0000, 1, 0, 4'b0000, 4'h0, 0, 0, 0);
        add(0,  39, 0, 16'h0050, 4'b0000, 1, 0, 4'b0000, 4'h0, 0, 1, 1);
        add(0,  42, 0, 16'h0050, 4'b0000, 1, 0, 4'b0001, 4'h0, 0, 0, 0);
        add(0,  45, 1, 16'h0000, 4'b0000, 1, 0, 4'b0001, 4'h0, 0, 0, 0);
        add(0,  52, 0, 16'h0000, 4'b0000, 1, 0, 4'b0010, 4'h5, 0, 0, 0);
        add(0,  62, 0, 16'h0000, 4'b0000, 1, 0, 4'b0000, 4'h0, 0, 0, 0);
        add(0,  72, 0, 16'h0000, 4'b0000, 1, 0, 4'b0000, 4'h0, 0, 0, 0);
        add(0,  79, 0, 16'h0000, 4'b0000, 1, 0, 4'b0000, 4'h0, 0, 1, 1);
        add(0,  82, 0, 16'h0000, 4'b0000, 1, 0, 4'b0001, 4'h0, 0, 0, 0);
        add(0,  85, 1, 16'h0005, 4'b0100, 1, 0, 4'b0001, 4'h0, 0, 0, 0);
        add(0,  92, 0, 16'h0005, 4'b0100, 1, 0, 4'b0000, 4'h0, 0, 0, 0);
        add(0, 102, 0, 16'h0005, 4'b0100, 1, 0, 4'b0000, 4'h0, 0, 0, 0);
        add(0, 112, 0, 16'h0005, 4'b0100, 1, 0, 4'b0000, 4'h0, 0, 0, 0);
        add(0, 119, 0, 16'h0005, 4'b0100, 1, 0, 4'b0000, 4'h0, 0, 1, 1);
        add(0, 122, 0, 16'h0005, 4'b0100, 1, 0, 4'b0001, 4'h5, 0, 0, 0);
        add(0, 132, 0, 16'h0005, 4'b0100, 1, 0, 4'b0010, 4'h0, 0, 0, 0);
        add(0, 142, 0, 16'h0005, 4'b0100, 1, 0, 4'b0100, 4'h0, 1, 0, 0);
        add(0, 152, 0, 16'h0005, 4'b0100, 1, 0, 4'b0000, 4'h0, 0, 0, 0);
        add(0, 159, 0, 16'h0005, 4'b0100, 1, 0, 4'b0000, 4'h0, 0, 1, 0);

        // Load on the boundary cycle, then two loads in one frame (last wins).
        add(1,  39, 1, 16'h9999, 4'b0000, 0, 0, 4'b1000, 4'h0, 0, 1, 1);
        add(0,  42, 0, 16'h9999, 4'b0000, 0, 0, 4'b0001, 4'h9, 0, 0, 0);
        add(0,  72, 0, 16'h9999, 4'b0000, 0, 0, 4'b1000, 4'h9, 0, 0, 0);
        add(0,  79, 0, 16'h9999, 4'b0000, 0, 0, 4'b1000, 4'h9, 0, 1, 0);
        add(0,  85, 1, 16'h5678, 4'b0001, 0, 0, 4'b0001, 4'h9, 0, 0, 0);
        add(0, 100, 1, 16'h8765, 4'b1000, 0, 0, 4'b0000, 4'h9, 0, 0, 0);
        add(0, 119, 0, 16'h8765, 4'b1000, 0, 0, 4'b1000, 4'h9, 0, 1, 1);
        add(0, 120, 0, 16'h8765, 4'b1000, 0, 0, 4'b0000, 4'h5, 0, 0, 0);
        add(0, 122, 0, 16'h8765, 4'b1000, 0, 0, 4'b0001, 4'h5, 0, 0, 0);
        add(0, 132, 0, 16'h8765, 4'b1000, 0, 0, 4'b0010, 4'h6, 0, 0, 0);
        add(0, 152, 0, 16'h8765, 4'b1000, 0, 0, 4'b1000, 4'h8, 1, 0, 0);
        add(0, 159, 0, 16'h8765, 4'b1000, 0, 0, 4'b1000, 4'h8, 1, 1, 0);

        // blank_all: selects go dark the cycle after it rises, scanning continues.
        add(1,   0, 1, 16'h4321, 4'b0000, 0, 0, 4'b0000, 4'h0, 0, 0, 0);
        add(0,  39, 0, 16'h4321, 4'b0000, 0, 0, 4'b1000, 4'h0, 0, 1, 1);
        add(0,  42, 0, 16'h4321, 4'b0000, 0, 0, 4'b0001, 4'h1, 0, 0, 0);
        add(0,  44, 0, 16'h4321, 4'b0000, 0, 1, 4'b0001, 4'h1, 0, 0, 0);
        add(0,  45, 0, 16'h4321, 4'b0000, 0, 1, 4'b0000, 4'h1, 0, 0, 0);
        add(0,  52, 0, 16'h4321, 4'b0000, 0, 1, 4'b0000, 4'h2, 0, 0, 0);
        add(0,  62, 0, 16'h4321, 4'b0000, 0, 1, 4'b0000, 4'h3, 0, 0, 0);
        add(0,  72, 0, 16'h4321, 4'b0000, 0, 1, 4'b0000, 4'h4, 0, 0, 0);
        add(0,  79, 0, 16'h4321, 4'b0000, 0, 1, 4'b0000, 4'h4, 0, 1, 0);
        add(0,  82, 0, 16'h4321, 4'b0000, 0, 1, 4'b0000, 4'h1, 0, 0, 0);
        add(0, 119, 0, 16'h4321, 4'b0000, 0, 1, 4'b0000, 4'h4, 0, 1, 0);
        add(0, 121, 0, 16'h4321, 4'b0000, 0, 0, 4'b0000, 4'h1, 0, 0, 0);
        add(0, 122, 0, 16'h4321, 4'b0000, 0, 0, 4'b0001, 4'h1, 0, 0, 0);

        foreach (vecs[k]) begin
            if (vecs[k].start) doReset();
            gotoCycle(vecs[k].cyc);
            applyStimulus(vecs[k]);
            #1;
            checkAll(vecs[k].cyc, vecs[k].e_sel, vecs[k].e_bcd, vecs[k].e_dp, vecs[k].e_fd, vecs[k].e_ack);
        end

        // Reset in the middle of a loaded frame with a load still pending.
        doReset();
        load = 1'b1; bcd_in = 16'h1234; dp_in = 4'b0100;
        gotoCycle(39);
        #1;
        checkAll(39, 4'b1000, 4'h0, 1'b0, 1'b1, 1'b1);
        gotoCycle(45);
        load = 1'b1; bcd_in = 16'h5555; dp_in = 4'b0000;
        gotoCycle(62);
        #1;
        checkAll(62, 4'b0100, 4'h2, 1'b1, 1'b0, 1'b0);
        gotoCycle(65);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkAll(0, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        gotoCycle(2);
        #1;
        checkAll(2, 4'b0001, 4'h0, 1'b0, 1'b0, 1'b0);
        gotoCycle(13);
        #1;
        checkAll(13, 4'b0010, 4'h0, 1'b0, 1'b0, 1'b0);
        gotoCycle(39);
        #1;
        checkAll(39, 4'b1000, 4'h0, 1'b0, 1'b1, 1'b0);
        gotoCycle(42);
        #1;
        checkAll(42, 4'b0001, 4'h0, 1'b0, 1'b0, 1'b0);

        // Pulse widths: three frames, one load, each pulse exactly one cycle wide.
        doReset();
        gotoCycle(3);
        load = 1'b1; bcd_in = 16'h0001; dp_in = 4'b0000;
        fd_count  = 0;
        ack_count = 0;
        for (int k = 4; k <= 122; k++) begin
            gotoCycle(k);
            #1;
            if (frame_done) fd_count++;
            if (load_ack)   ack_count++;
        end
        checkOutput("frame_done_count", 122, 4'(fd_count), 4'd3);
        checkOutput("load_ack_count", 122, 4'(ack_count), 4'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
